// File: rtl/dbg_soc_osd_dem_uart_bus.sv
// 16550-subset register front end for the DEM UART: TX/RX byte FIFOs behind a req/ack bus; optional IRQ via DBG_SOC_DEM_UART_BUS_IRQ_EN.
// Bus ack/rdata one cycle after acceptance; TX drops on full (sticky TXO), RX backpressures losslessly via in_ready.
module dbg_soc_osd_dem_uart_bus #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_req,
    input  logic       bus_we,
    input  logic [2:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          r_ack;
    logic [7:0]    r_rdata;
    logic          r_txo;
    logic          r_in_ready;
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_rx_cnt;

    logic          w_acc, w_wr, w_rd;
    logic          w_tx_empty, w_tx_full, w_thr_wr, w_tx_push, w_tx_pop, w_txo_set;
    logic          w_rx_empty, w_rx_push, w_rx_pop;
    logic [CW-1:0] w_rx_cnt_nxt;
    logic          w_dr, w_thre, w_lsr_rd;
    logic [1:0]    w_ier;
    logic [7:0]    w_iir, w_rdata;

    // A request is only sampled while no ack is in flight, giving one access per two cycles.
    assign w_acc = bus_req & ~r_ack;
    assign w_wr  = w_acc & bus_we;
    assign w_rd  = w_acc & ~bus_we;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_thr_wr   = w_wr & (bus_addr == 3'd0);
    assign w_tx_push  = w_thr_wr & ~w_tx_full;
    assign w_txo_set  = w_thr_wr & w_tx_full;
    assign w_tx_pop   = ~w_tx_empty & out_ready;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_push  = in_valid & r_in_ready;
    assign w_rx_pop   = w_rd & (bus_addr == 3'd0) & ~w_rx_empty;

    assign w_dr     = ~w_rx_empty;
    assign w_thre   = w_tx_empty;
    assign w_lsr_rd = w_rd & (bus_addr == 3'd5);

    assign out_valid = ~w_tx_empty;
    assign out_char  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];
    assign in_ready  = r_in_ready;
    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;

    always_comb begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (w_rx_push && !w_rx_pop)
            w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        else if (!w_rx_push && w_rx_pop)
            w_rx_cnt_nxt = r_rx_cnt - CW'(1);
    end

    always_comb begin
        w_iir = 8'h01;
        if (w_ier[0] && w_dr)
            w_iir = 8'h04;
        else if (w_ier[1] && w_thre)
            w_iir = 8'h02;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (bus_addr)
            3'd0:    w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
            3'd1:    w_rdata = {6'b0, w_ier};
            3'd2:    w_rdata = w_iir;
            3'd5:    w_rdata = {1'b0, w_thre, w_thre, 2'b00, r_txo, 1'b0, w_dr};
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
            r_txo   <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= w_rd ? w_rdata : 8'h00;
            // An overflow landing with the LSR read keeps TXO set.
            r_txo   <= w_txo_set | (r_txo & ~w_lsr_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= bus_wdata;
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= in_char;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)
                r_tx_rp <= r_tx_rp + PW'(1);
            if (w_tx_push && !w_tx_pop)
                r_tx_cnt <= r_tx_cnt + CW'(1);
            else if (!w_tx_push && w_tx_pop)
                r_tx_cnt <= r_tx_cnt - CW'(1);
        end
    end

    // in_ready is registered from the next count so it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_cnt   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_rx_push)
                r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + PW'(1);
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_in_ready <= (w_rx_cnt_nxt != FULL_CNT);
        end
    end

`ifdef DBG_SOC_DEM_UART_BUS_IRQ_EN
    logic [1:0] r_ier;
    logic       r_irq;

    assign w_ier = r_ier;
    assign irq   = r_irq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ier <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && (bus_addr == 3'd1))
                r_ier <= bus_wdata[1:0];
            r_irq <= (r_ier[0] & w_dr) | (r_ier[1] & w_thre);
        end
    end
`else
    assign w_ier = 2'b00;
    assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_soc_osd_dem_uart_bus.sv
// Scoreboard bench for the DEM UART bus front end: TX/RX byte queues checked against the stream and RBR reads.
module tb_dbg_soc_osd_dem_uart_bus;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_req, bus_we;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       bus_ack;
    logic [7:0] out_char;
    logic       out_valid, out_ready;
    logic [7:0] in_char;
    logic       in_valid, in_ready;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    dbg_soc_osd_dem_uart_bus #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
        .irq(irq)
    );

    // Stream monitor: handshakes seen at negedge complete at the next posedge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                n_errors++;
                $display("FAIL tx_stream: unexpected byte %h, none expected", out_char);
            end else begin
                logic [7:0] exp_b;
                exp_b = tx_q.pop_front();
                if (out_char !== exp_b) begin
                    n_errors++;
                    $display("FAIL tx_stream: got %h expected %h", out_char, exp_b);
                end
            end
        end
        if (rst && in_valid && in_ready)
            rx_q.push_back(in_char);
    end

    task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [7:0] wd,
                            output logic [7:0] rd);
        bit got;
        got = 0;
        rd = 8'h00;
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus_ack) begin
                rd = bus_rdata;
                got = 1;
                break;
            end
        end
        bus_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL bus_ack_timeout: addr=%0d ack=%b expected 1", a, bus_ack);
        end
    endtask

    task automatic thr_write(input logic [7:0] b);
        logic [7:0] d;
        if (tx_q.size() < DEPTH)
            tx_q.push_back(b);
        bus_xfer(1'b1, 3'd0, b, d);
    endtask

    task automatic rx_send(input logic [7:0] b);
        bit got;
        got = 0;
        in_char = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL rx_send_timeout: byte %h in_ready=%b expected 1", b, in_ready);
        end
    endtask

    task automatic wait_tx_drained(input string name);
        for (int i = 0; i < 40 && out_valid; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0 || tx_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: out_valid=%b pending=%0d expected 0/0", name, out_valid, tx_q.size());
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b0; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
        out_ready = 0; in_char = 0; in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_ack, out_valid, in_ready, irq} !== 4'b0000 || bus_rdata !== 8'h00 || out_char !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: ack/ov/ir/irq=%b%b%b%b rdata=%h char=%h expected 0000/00/00",
                     bus_ack, out_valid, in_ready, irq, bus_rdata, out_char);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h60) begin n_errors++; $display("FAIL reset_lsr: got %h expected 60", d); end
        bus_xfer(1'b0, 3'd2, 8'h00, d);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL reset_iir: got %h expected 01", d); end
    endtask

    task automatic test_tx_path;
        logic [7:0] d;
        out_ready = 1'b0;
        thr_write(8'h41); thr_write(8'h42); thr_write(8'h43);
        n_checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h41) begin
            n_errors++;
            $display("FAIL tx_head: valid=%b char=%h expected 1/41", out_valid, out_char);
        end
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL tx_lsr_busy: got %h expected 00", d); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL tx_consecutive: cycle %0d out_valid=%b expected 1", i, out_valid);
            end
        end
        @(posedge clk); #1;
        wait_tx_drained("tx_path");
        out_ready = 1'b0;
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h60) begin n_errors++; $display("FAIL tx_lsr_idle: got %h expected 60", d); end
    endtask

    task automatic test_tx_overflow;
        logic [7:0] d;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            thr_write(8'h80 + 8'(i));
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h04) begin n_errors++; $display("FAIL txo_lsr: got %h expected 04", d); end
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL txo_cleared: got %h expected 00", d); end
        out_ready = 1'b1;
        wait_tx_drained("tx_overflow");
        out_ready = 1'b0;
    endtask

    task automatic test_rx_path;
        logic [7:0] d, e;
        rx_send(8'h55);
        rx_send(8'hAA);
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h61) begin n_errors++; $display("FAIL rx_lsr_dr: got %h expected 61", d); end
        for (int i = 0; i < 3; i++) begin
            e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            bus_xfer(1'b0, 3'd0, 8'h00, d);
            n_checks++;
            if (d !== e) begin n_errors++; $display("FAIL rx_rbr_%0d: got %h expected %h", i, d, e); end
        end
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h60) begin n_errors++; $display("FAIL rx_lsr_empty: got %h expected 60", d); end
    endtask

    task automatic test_rx_full_concurrent;
        logic [7:0] d, e;
        for (int i = 0; i < DEPTH; i++)
            rx_send(8'hB0 + 8'(i));
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rx_full_ready: got %b expected 0", in_ready); end
        fork
            rx_send(8'h99);
            bus_xfer(1'b0, 3'd0, 8'h00, d);
        join
        e = rx_q.pop_front();
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL rx_concurrent_rbr: got %h expected %h", d, e); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rx_refull_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            bus_xfer(1'b0, 3'd0, 8'h00, d);
            n_checks++;
            if (d !== e) begin n_errors++; $display("FAIL rx_drain_%0d: got %h expected %h", i, d, e); end
        end
    endtask

    task automatic test_irq;
        logic [7:0] d;
`ifdef DBG_SOC_DEM_UART_BUS_IRQ_EN
        bus_xfer(1'b1, 3'd1, 8'h03, d);
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_thre: got %b expected 1", irq); end
        bus_xfer(1'b0, 3'd2, 8'h00, d);
        n_checks++;
        if (d !== 8'h02) begin n_errors++; $display("FAIL iir_thre: got %h expected 02", d); end
        rx_send(8'h10);
        bus_xfer(1'b0, 3'd2, 8'h00, d);
        n_checks++;
        if (d !== 8'h04) begin n_errors++; $display("FAIL iir_rda: got %h expected 04", d); end
        bus_xfer(1'b0, 3'd0, 8'h00, d);
        n_checks++;
        if (d !== rx_q.pop_front()) begin n_errors++; $display("FAIL irq_rbr: got %h expected 10", d); end
        bus_xfer(1'b1, 3'd1, 8'h00, d);
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_off: got %b expected 0", irq); end
`else
        bus_xfer(1'b1, 3'd1, 8'h03, d);
        bus_xfer(1'b0, 3'd1, 8'h00, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL ier_absent: got %h expected 00", d); end
        bus_xfer(1'b0, 3'd2, 8'h00, d);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL iir_absent: got %h expected 01", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_absent: got %b expected 0", irq); end
`endif
    endtask

    task automatic test_back_to_back;
        int  cyc;
        bit  got;
        out_ready = 1'b1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd0;
        for (int i = 0; i < 4; i++) begin
            bus_wdata = 8'h20 + 8'(i);
            tx_q.push_back(bus_wdata);
            cyc = 0; got = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                cyc++;
                if (bus_ack) begin got = 1; break; end
            end
            n_checks++;
            if (!got || (i > 0 && cyc != 2)) begin
                n_errors++;
                $display("FAIL b2b_ack_%0d: acked=%0d after %0d cycles, expected 1 after 2", i, got, cyc);
            end
        end
        bus_req = 1'b0;
        wait_tx_drained("b2b");
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        out_ready = 1'b0;
        thr_write(8'h61); thr_write(8'h62); thr_write(8'h63);
        rst = 1'b0;
        @(posedge clk); #1;
        tx_q.delete();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus_xfer(1'b0, 3'd5, 8'h00, d);
        n_checks++;
        if (d !== 8'h60) begin n_errors++; $display("FAIL rstmid_lsr: got %h expected 60", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_path();
        test_tx_overflow();
        test_rx_path();
        test_rx_full_concurrent();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dbg_soc_osd_dem_uart_bus.md
# dbg_soc_osd_dem_uart_bus

CPU-side front end of the debug UART device-emulation module. Exposes a small 16550-subset register file on a simple request/acknowledge slave bus. Buffers transmit bytes in a TX FIFO that drives the DEM UART `out_char`/`out_valid`/`out_ready` handshake. Buffers received bytes from the DEM UART `in_char`/`in_valid`/`in_ready` handshake in an RX FIFO, and optionally raises an interrupt.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: entries per FIFO. Must be a power of two and ≥2.

Ports:
- `clk`: in, 1. Single clock; every register updates on its rising edge.
- `rst`: in, 1. Reset is synchronous and active-low.
- `bus_req`: in, 1. Access request.
- `bus_we`: in, 1. 1 = write, 0 = read.
- `bus_addr`: in, 3. Register address.
- `bus_wdata`: in, 8. Write data.
- `bus_rdata`: out, 8. Read data. Valid only while `bus_ack`=1, 0 otherwise.
- `bus_ack`: out, 1. One-cycle access acknowledge.
- `out_char`: out, 8. TX FIFO head, to DEM UART.
- `out_valid`: out, 1. TX FIFO not empty.
- `out_ready`: in, 1. DEM UART accepts `out_char`.
- `in_char`: in, 8. Received byte from DEM UART.
- `in_valid`: in, 1. `in_char` valid.
- `in_ready`: out, 1. RX FIFO not full.
- `irq`: out, 1. Level interrupt.

## Operation
- **Bus acceptance.** `bus_req` is sampled only while `bus_ack`=0. An accepted access produces `bus_ack`=1 for exactly one cycle. A request held high across `bus_ack` is accepted again on the cycle after the ack. Every address is acknowledged.
- **Addr 0, write (THR).** Push `bus_wdata` into the TX FIFO. If the TX FIFO is full, drop the byte and set the sticky TXO flag. Fullness is evaluated before any same-cycle pop.
- **Addr 0, read (RBR).** Return the RX FIFO head and pop it. If the RX FIFO is empty, return 0x00 and do not pop.
- **Addr 1 (IER), read/write.** bit0 = RX-data-available enable, bit1 = THR-empty enable. Other bits read 0.
- **Addr 2 (IIR), read-only.** Returns 0x04 if (IER0 & DR), else 0x02 if (IER1 & THRE), else 0x01.
- **Addr 5 (LSR), read-only.**
  - bit0 DR = RX FIFO not empty.
  - bit2 TXO = sticky TX overflow.
  - bit5 THRE = TX FIFO empty.
  - bit6 TEMT = TX FIFO empty.
  - Other bits 0.
  - Reading LSR clears TXO. A TXO set in the same cycle as the read wins (TXO stays set).
- **Other addresses.** Read 0; writes ignored.
- **TX FIFO.** Show-ahead: `out_char` = head, `out_valid` = !empty. Pops on `out_valid & out_ready`.
- **RX FIFO.** `in_ready` = !full. Pushes on `in_valid & in_ready`. Backpressure is lossless: no RX byte is ever dropped.
- **Pointers and count.** Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The occupancy count is $clog2(FIFO_DEPTH)+1 bits.
- **Simultaneous push and pop** on one FIFO: both occur and the count is unchanged. This holds on an empty TX FIFO only if the head was already valid; on an empty FIFO, only the push occurs.
- **`irq`** is registered: `irq` <= (IER0 & DR) | (IER1 & THRE), evaluated each cycle.

## Timing
- **Reset.** While `rst`=0 at a rising edge, the following are cleared to 0: `bus_ack`, `bus_rdata`, `irq`, `out_valid`, `out_char`, `in_ready`, IER, TXO, and both FIFO pointers and counts. `in_ready` becomes 1 in the first cycle after `rst` returns high.
- **Reset mid-operation.** Both FIFOs are flushed. A byte already handshaken into the DEM UART is unaffected. Any outstanding bus access is not acknowledged.
- **Access latency.** A request is sampled at edge E. `bus_ack` and `bus_rdata` are valid in the cycle after E. All register/FIFO side effects take place at E.
- **TX visibility.** After a THR write at E, `out_valid`=1 in the same cycle as `bus_ack`.
- **RX visibility.** After an RX push at E, DR=1 for a read sampled at E+1. `irq` rises one cycle after its condition becomes true.
- **Throughput.** The bus sustains one access every 2 cycles. The FIFO stream ports sustain 1 byte/cycle.

## Configuration
- Macro `DBG_SOC_DEM_UART_BUS_IRQ_EN`.
- **Defined:** IER, IIR and `irq` behave as specified above.
- **Undefined:** no IER storage. IER reads 0x00 and writes are ignored. IIR reads 0x01. `irq` is tied to 0. The FIFO and LSR behaviour is unchanged.

## Test plan
- **Reset.** Reset, then release. Expect `in_ready`=1, `out_valid`=0, LSR=0x60, IIR=0x01, `irq`=0.
- **TX path.** Hold `out_ready`=0 and write 0x41, 0x42, 0x43 to addr 0. Expect `out_char`=0x41 with `out_valid`=1, LSR=0x00. Raise `out_ready`: 0x41, 0x42, 0x43 appear on consecutive cycles, then LSR=0x60.
- **TX overflow.** With `out_ready`=0, write 9 bytes (DEPTH 8). Expect LSR=0x04, 9th byte absent from the drained output stream. A second LSR read returns 0x00 while the FIFO is still full.
- **RX path.** Drive 0x55 then 0xAA on `in_char`. Expect LSR bit0=1, addr0 reads 0x55 then 0xAA, a third read returns 0x00 with DR=0. Push 8 bytes without reading: `in_ready`=0 and the 9th byte is held, not dropped.
- **Interrupt (macro defined).** Write IER=0x03 with TX empty. Expect `irq`=1 and IIR=0x02. Push RX byte 0x10: IIR=0x04. Read RBR and write IER=0x00: `irq`=0 one cycle later.
- **Concurrency and reset.** On a full RX FIFO, issue an RBR read in the same cycle as `in_valid`=1. Expect the count to stay at 8 and the data order preserved. Assert `rst`=0 with the TX FIFO holding 3 bytes: `out_valid`=0 on the next cycle and LSR=0x60 after release.
